// File: rtl/rt_merge_pkg.sv
// Shared types and helpers for the two-input round-robin FIFO merge stage.
package rt_merge_pkg;

  // Source index carried alongside each merged entry.
  typedef logic merge_src_t;

  // Depth of the output skid queue between the sources and downstream.
  localparam int MERGE_Q_DEPTH = 2;

  // Round-robin grant between two show-ahead sources.
  // Returns a one-hot (or zero) grant vector: bit 0 = source 0, bit 1 = source 1.
  // On contention the source that did not win last time is chosen.
  function automatic logic [1:0] rr_grant(
    input logic       empty0,
    input logic       empty1,
    input merge_src_t last_grant
  );
    logic [1:0] grant;
    grant = 2'b00;
    if (!empty0 && !empty1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (!empty0) begin
      grant = 2'b01;
    end else if (!empty1) begin
      grant = 2'b10;
    end
    return grant;
  endfunction

endpackage

// File: rtl/ff_ar.sv
// Plain D flop bank with asynchronous active-high reset to a parameterised value.
module ff_ar #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register d every cycle; rst forces RST_VAL immediately.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ff_ar_en.sv
// D flop bank with load enable and asynchronous active-high reset.
module ff_ar_en #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when en is high, otherwise hold; rst forces RST_VAL immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/out_q2.sv
// Two-entry in-order output queue (head + skid tail) with a valid/stall read side.
// The head register always drives the downstream data; the tail only fills when
// a push arrives while the head is stalled.
module out_q2
  import rt_merge_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ok,
  output logic         valid,
  output logic [W-1:0] head_data,
  output logic         full
);

  localparam logic [1:0] OCC_FULL = 2'(MERGE_Q_DEPTH);

  logic [1:0]   occ;
  logic [1:0]   occ_d;
  logic [W-1:0] head_q;
  logic [W-1:0] head_d;
  logic [W-1:0] tail_q;
  logic         head_en;
  logic         tail_en;
  logic         xfer;

  assign valid     = (occ != 2'd0);
  assign full      = (occ == OCC_FULL);
  assign xfer      = valid & pop_ok;
  assign head_data = head_q;

  // Decide which queue register loads this cycle and the next occupancy.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    head_en = 1'b0;
    head_d  = push_data;
    tail_en = 1'b0;
    occ_d   = occ;
    case (occ)
      2'd0: begin
        head_en = push;
        occ_d   = push ? 2'd1 : 2'd0;
      end
      2'd1: begin
        // Simultaneous push and transfer replaces the head and keeps occ at 1.
        head_en = push & xfer;
        tail_en = push & ~xfer;
        occ_d   = 2'(occ + {1'b0, push} - {1'b0, xfer});
      end
      2'd2: begin
        // Full: no push can arrive, the skid entry moves up on transfer.
        head_en = xfer;
        head_d  = tail_q;
        occ_d   = xfer ? 2'd1 : 2'd2;
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
  end

  // NOTE: the two data registers are reset as well, so ds_data reads 0 out of reset.
  ff_ar #(.W(2), .RST_VAL(2'd0)) u_occ (
    .clk (clk),
    .rst (rst),
    .d   (occ_d),
    .q   (occ)
  );

  ff_ar_en #(.W(W), .RST_VAL('0)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (head_en),
    .d   (head_d),
    .q   (head_q)
  );

  ff_ar_en #(.W(W), .RST_VAL('0)) u_tail (
    .clk (clk),
    .rst (rst),
    .en  (tail_en),
    .d   (push_data),
    .q   (tail_q)
  );

`ifndef SYNTHESIS
  // Occupancy is bounded by the queue depth.
  occ_bound_a: assert property (@(posedge clk) disable iff (rst) occ <= OCC_FULL);
  // The producer never pushes into a full queue.
  no_push_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));
`endif

endmodule

// File: rtl/rr_fifo_merge2.sv
// Two-input round-robin merge of show-ahead FIFO sources into a valid/stall stream.
// Pops at most one source per cycle, tags the entry with its source index and
// queues it in a 2-entry skid buffer. rdreq depends only on registered state,
// rst and the empty inputs, never on ds_stall.
module rr_fifo_merge2
  import rt_merge_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter logic FAIR_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty0,
  input  logic [WIDTH-1:0] data0,
  output logic             rdreq0,
  input  logic             empty1,
  input  logic [WIDTH-1:0] data1,
  output logic             rdreq1,
  output logic             ds_valid,
  output logic [WIDTH-1:0] ds_data,
  output merge_src_t       ds_src,
  input  logic             ds_stall
);

  localparam int PW = WIDTH + 1;

  merge_src_t    last_grant;
  merge_src_t    push_src;
  logic [1:0]    grant;
  logic          can_pop;
  logic          full;
  logic          pop;
  logic [PW-1:0] push_data;
  logic [PW-1:0] head;

  // Room in the queue is judged from registered occupancy only.
  assign can_pop = ~full;
  assign grant   = rr_grant(empty0, empty1, last_grant);

  assign rdreq0  = ~rst & can_pop & grant[0];
  assign rdreq1  = ~rst & can_pop & grant[1];
  assign pop     = rdreq0 | rdreq1;

  // The popped entry is tagged with the granted source and its head data.
  assign push_src  = rdreq1;
  assign push_data = {push_src, (push_src ? data1 : data0)};

  // last_grant remembers the most recent winner; it only moves on an actual pop.
  ff_ar_en #(.W(1), .RST_VAL(FAIR_RST)) u_last_grant (
    .clk (clk),
    .rst (rst),
    .en  (pop),
    .d   (push_src),
    .q   (last_grant)
  );

  out_q2 #(.W(PW)) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .push      (pop),
    .push_data (push_data),
    .pop_ok    (~ds_stall),
    .valid     (ds_valid),
    .head_data (head),
    .full      (full)
  );

  assign ds_src  = head[WIDTH];
  assign ds_data = head[WIDTH-1:0];

`ifndef SYNTHESIS
  // Only one source is popped per cycle.
  one_rdreq_a: assert property (@(posedge clk) disable iff (rst) !(rdreq0 && rdreq1));
  // A source is never popped while it reports empty.
  no_pop_empty0_a: assert property (@(posedge clk) disable iff (rst) !(rdreq0 && empty0));
  no_pop_empty1_a: assert property (@(posedge clk) disable iff (rst) !(rdreq1 && empty1));
`endif

endmodule

// File: tb/tb_rr_fifo_merge2.sv
// Self-checking bench for rr_fifo_merge2. Two show-ahead source FIFOs are
// modelled as queues; a reference arbiter predicts rdreq every cycle and a
// scoreboard of {src, data} predicts the downstream stream.
module tb_rr_fifo_merge2;

  localparam int   WIDTH    = 32;
  localparam logic FAIR_RST = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             empty0 = 1'b1;
  logic [WIDTH-1:0] data0 = '0;
  logic             rdreq0;
  logic             empty1 = 1'b1;
  logic [WIDTH-1:0] data1 = '0;
  logic             rdreq1;
  logic             ds_valid;
  logic [WIDTH-1:0] ds_data;
  logic             ds_src;
  logic             ds_stall = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] src0[$];
  logic [WIDTH-1:0] src1[$];
  logic [WIDTH:0]   sb[$];
  logic             m_last = FAIR_RST;
  int               n0 = 0;
  int               n1 = 0;

  rr_fifo_merge2 #(.WIDTH(WIDTH), .FAIR_RST(FAIR_RST)) dut (
    .clk      (clk),
    .rst      (rst),
    .empty0   (empty0),
    .data0    (data0),
    .rdreq0   (rdreq0),
    .empty1   (empty1),
    .data1    (data1),
    .rdreq1   (rdreq1),
    .ds_valid (ds_valid),
    .ds_data  (ds_data),
    .ds_src   (ds_src),
    .ds_stall (ds_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Present the head of each source queue as a show-ahead FIFO would.
  task automatic drive_src();
    empty0 = (src0.size() == 0);
    data0  = empty0 ? '0 : src0[0];
    empty1 = (src1.size() == 0);
    data1  = empty1 ? '0 : src1[0];
  endtask

  task automatic add_src(input logic which);
    if (which) begin
      src1.push_back(32'hB000_0000 + 32'(n1));
      n1++;
    end else begin
      src0.push_back(32'hA000_0000 + 32'(n0));
      n0++;
    end
  endtask

  // One clock cycle: check at the negedge, then update sources after the posedge.
  // Called at posedge+1 and returns at posedge+1.
  task automatic tick(input logic stall_nxt, input logic add0, input logic add1);
    logic e0, e1, cp, x0, x1, xfer;
    @(negedge clk);
    e0 = (src0.size() == 0);
    e1 = (src1.size() == 0);
    cp = !rst && (sb.size() < 2);
    x0 = cp && !e0 && (e1 || m_last);
    x1 = cp && !e1 && (e0 || !m_last);
    check("rdreq0", 64'(rdreq0), 64'(x0));
    check("rdreq1", 64'(rdreq1), 64'(x1));
    check("ds_valid", 64'(ds_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) check("ds_head", 64'({ds_src, ds_data}), 64'(sb[0]));
    xfer = (sb.size() != 0) && !ds_stall && !rst;
    if (xfer) void'(sb.pop_front());
    if (x0) begin
      sb.push_back({1'b0, src0[0]});
      m_last = 1'b0;
    end
    if (x1) begin
      sb.push_back({1'b1, src1[0]});
      m_last = 1'b1;
    end
    @(posedge clk);
    #1;
    if (x0) void'(src0.pop_front());
    if (x1) void'(src1.pop_front());
    if (add0) add_src(1'b0);
    if (add1) add_src(1'b1);
    drive_src();
    ds_stall = stall_nxt;
  endtask

  // Assert rst for part of a cycle; sources and scoreboard are cleared with it.
  task automatic apply_reset();
    rst = 1'b1;
    src0.delete();
    src1.delete();
    sb.delete();
    m_last   = FAIR_RST;
    ds_stall = 1'b0;
    drive_src();
    @(negedge clk);
    check("rst_rdreq0", 64'(rdreq0), 64'(0));
    check("rst_rdreq1", 64'(rdreq1), 64'(0));
    check("rst_valid", 64'(ds_valid), 64'(0));
    check("rst_data", 64'(ds_data), 64'(0));
    check("rst_src", 64'(ds_src), 64'(0));
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Run with no stall until everything queued has been delivered (bounded).
  task automatic drain();
    int budget;
    budget = 64;
    while (budget > 0 && (sb.size() != 0 || src0.size() != 0 || src1.size() != 0)) begin
      tick(1'b0, 1'b0, 1'b0);
      budget--;
    end
    check("drain_left", 64'(sb.size() + src0.size() + src1.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_src();
    apply_reset();

    // Idle with both sources empty.
    repeat (10) tick(1'b0, 1'b0, 1'b0);

    // Source 0 only, four entries, no stall.
    repeat (4) add_src(1'b0);
    drive_src();
    drain();

    // Both sources with three entries: strict alternation starting at port 0.
    apply_reset();
    repeat (3) begin
      add_src(1'b0);
      add_src(1'b1);
    end
    drive_src();
    drain();

    // Both sources busy; downstream stalls for cycles 2..4.
    apply_reset();
    repeat (4) begin
      add_src(1'b0);
      add_src(1'b1);
    end
    drive_src();
    for (int c = 0; c < 12; c++) tick(1'(c >= 1 && c <= 3), 1'b0, 1'b0);
    drain();

    // Source 1 streams eight entries under stall pulses every other cycle.
    apply_reset();
    repeat (8) add_src(1'b1);
    drive_src();
    for (int c = 0; c < 24; c++) tick(1'(c % 2 == 0), 1'b0, 1'b0);
    drain();

    // Fill the queue to two entries under stall, then reset mid-stream.
    apply_reset();
    repeat (4) begin
      add_src(1'b0);
      add_src(1'b1);
    end
    drive_src();
    ds_stall = 1'b1;
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    apply_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    // Random source fill and downstream stall.
    apply_reset();
    for (int c = 0; c < 10000; c++) begin
      tick(1'($urandom_range(0, 3) == 0),
           1'(src0.size() < 4 && $urandom_range(0, 2) != 0),
           1'(src1.size() < 4 && $urandom_range(0, 2) != 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
